stepper_positioner: RTL and testbench
=====================================

# stepper_positioner

Trapezoidal-profile position controller that sits directly upstream of the unipolar stepper phase driver. It accepts an absolute target position through a valid/ready command port and tracks the current position in a signed counter. It emits one-cycle step pulses plus a direction level for the phase driver to consume, and ramps the step rate up and down in discrete speed levels.

## Interface
- POS_W, 16, width of signed position/target (two's complement, wraps modulo 2^POS_W)
- BASE, 10, clk cycles per speed unit; step period = BASE*(8-lvl) cycles; legal range 1..127
- RAMP_STEPS, 4, steps spent at each speed level while accelerating; legal range 1..15

Ports:
- clk  in  1  system clock (1 ms tick domain)
- rstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_target  in  POS_W  absolute target position, signed
- cmd_vmax  in  3  maximum speed level; 7 is fastest
- abort  in  1  level; requests a controlled stop
- step  out  1  one-cycle pulse per motor step
- dir  out  1  1 = position increments, 0 = position decrements
- position  out  POS_W  current position
- busy  out  1  high in ACCEL/CRUISE/DECEL
- done  out  1  one-cycle pulse at move completion
- aborted  out  1  high with done when the move ended by abort; held until next accept

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL.
- Internal registers:
  - lvl (3 b)
  - rampcnt (4 b)
  - remaining (POS_W+1 b, unsigned)
  - interval counter (10 b)
  - vmax (latched)
- Accept = cmd_valid & cmd_ready.
  - On accept, delta = cmd_target - position, computed in POS_W+1 bits, signed.
  - delta == 0: stay IDLE; pulse done next edge with step=0.
  - delta != 0:
    - dir <= (delta > 0).
    - remaining <= |delta|; lvl <= 0; rampcnt <= 0.
    - Interval counter <= BASE*8.
    - Next state: CRUISE if cmd_vmax == 0, else ACCEL.
- While busy, the interval counter decrements each cycle. On reaching 1, a step edge occurs:
  - step <= 1.
  - position +/-= 1 per dir, with wrap.
  - remaining -= 1.
  - Counter reloaded with the period of the updated lvl.
- Per-step updates are evaluated on the post-decrement remaining, in this priority order:
  1. remaining == 0 → IDLE, done <= 1 (coincident with the final step pulse), busy <= 0.
  2. ACCEL:
     - If remaining <= lvl*RAMP_STEPS → DECEL.
     - Else rampcnt++. When rampcnt hits RAMP_STEPS: rampcnt <= 0, lvl++, and go to CRUISE if the new lvl == vmax.
  3. CRUISE: remaining <= lvl*RAMP_STEPS → DECEL.
  4. DECEL: if lvl > 0 and remaining == (lvl-1)*RAMP_STEPS → lvl--.
- abort, sampled every cycle while busy (ACCEL/CRUISE):
  - lvl == 0: immediate stop, no further step. Go IDLE, done = 1, aborted = 1.
  - Otherwise: remaining <= min(remaining, lvl*RAMP_STEPS), enter DECEL, set aborted.
  - In DECEL, abort has no further effect. In IDLE it is ignored.
- cmd_valid while busy is ignored, with no queuing.
- Position arithmetic wraps modulo 2^POS_W. remaining uses POS_W+1 bits so that a full-range delta is representable.

## Timing
- Reset values:
  - IDLE, step 0, dir 1, position 0, busy 0, done 0, aborted 0, cmd_ready 1.
  - lvl 0, remaining 0.
- Reset mid-move: all outputs return to reset values asynchronously. The move is lost.
- First step pulse arrives BASE*8 cycles after the accept edge.
- Subsequent step spacing equals BASE*(8-lvl), using the lvl in force after the previous step's update.
- busy rises on the edge after accept. cmd_ready is the inverse of busy.
- On the completion edge, done and step are both 1 and cmd_ready returns to 1. A new command may be accepted in the same cycle that done is high.
- dir is stable from accept until the next accept; it never changes mid-move.
- step and done are registered outputs with no combinational path from the inputs.

## Test plan
All scenarios use BASE=10 and RAMP_STEPS=4.
- Reset check: hold rstn low → position 0, cmd_ready 1, busy 0, step/done 0. Release → no step pulses occur without a command.
- Slow move, target 3, vmax 0:
  - 3 steps at 80-cycle spacing, first step 80 cycles after accept.
  - dir 1; position 3; done coincident with the 3rd step.
- Full trapezoid, target 100 from 0, vmax 7:
  - Spacing 80 for steps 1–4, then 70, 60, … down to 10 at lvl 7 after step 28.
  - Cruise until remaining 28, then mirror deceleration.
  - Exactly 100 steps, position 100.
- Triangular move, target 10, vmax 7: lvl never exceeds 1; DECEL entered after step 6; 10 steps total.
- Negative wrap, position 5, target 0xFFFE:
  - dir 0; 7 steps; position passes through 0 to 0xFFFE.
  - A cmd_valid asserted during the move is ignored.
- Abort at lvl 7 in cruise, 50 steps remaining:
  - Exactly 28 further steps, decelerating.
  - Then done=1 with aborted=1.
  - Abort asserted at lvl 0 instead → done next edge with no extra step.

Source files
------------

// File: rtl/stepper_positioner.sv
// Trapezoidal-profile stepper position controller.
// Accepts an absolute target, ramps the step rate through speed levels 0..7
// and emits one-cycle step pulses plus a direction level for the phase driver.
module stepper_positioner #(
  parameter int unsigned POS_W      = 16,
  parameter int unsigned BASE       = 10,
  parameter int unsigned RAMP_STEPS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  input  logic [2:0]       cmd_vmax,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   rem_t;
  typedef logic [9:0]       cnt_t;

  typedef enum logic [1:0] {StIdle, StAccel, StCruise, StDecel} state_e;

  localparam logic [3:0] RampLast    = 4'(RAMP_STEPS);
  localparam cnt_t       FirstPeriod = cnt_t'(BASE * 8);

  // Cycles between steps at speed level l.
  function automatic cnt_t period(input logic [2:0] l);
    return cnt_t'(BASE) * (cnt_t'(8) - cnt_t'(l));
  endfunction

  // Steps needed to ramp down from level l to a stop.
  function automatic rem_t span(input logic [2:0] l);
    return rem_t'(l) * rem_t'(RAMP_STEPS);
  endfunction

  state_e     state_q, state_d;
  logic [2:0] lvl_q, lvl_d;
  logic [3:0] rampcnt_q, rampcnt_d;
  rem_t       remaining_q, remaining_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] vmax_q, vmax_d;
  logic       step_q, step_d;
  logic       done_q, done_d;
  logic       dir_q, dir_d;
  pos_t       position_q, position_d;
  logic       aborted_q, aborted_d;

  rem_t       delta;
  state_e     st_eff;
  rem_t       rem_eff;
  rem_t       rem_dec;
  logic [2:0] lvl_new;

  // Next-state: command accept, interval timing, per-step profile update, abort.
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    rampcnt_d   = rampcnt_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    vmax_d      = vmax_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    dir_d       = dir_q;
    position_d  = position_q;
    aborted_d   = aborted_q;
    // Sign-extended difference so a full-range move is representable.
    delta       = {cmd_target[POS_W-1], cmd_target} - {position_q[POS_W-1], position_q};
    st_eff      = state_q;
    rem_eff     = remaining_q;
    rem_dec     = remaining_q;
    lvl_new     = lvl_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          aborted_d = 1'b0;
          if (delta == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d       = ~delta[POS_W];
            remaining_d = delta[POS_W] ? (~delta + rem_t'(1)) : delta;
            lvl_d       = '0;
            rampcnt_d   = '0;
            cnt_d       = FirstPeriod;
            vmax_d      = cmd_vmax;
            state_d     = (cmd_vmax == 3'd0) ? StCruise : StAccel;
          end
        end
      end

      StAccel, StCruise, StDecel: begin
        if (abort && (state_q != StDecel)) begin
          if (lvl_q != 3'd0) begin
            // Clamp the move to what is needed to ramp down from here.
            st_eff    = StDecel;
            rem_eff   = (remaining_q < span(lvl_q)) ? remaining_q : span(lvl_q);
            aborted_d = 1'b1;
          end
        end

        if (abort && (state_q != StDecel) && (lvl_q == 3'd0)) begin
          // Already at crawl speed: stop without another step.
          state_d     = StIdle;
          done_d      = 1'b1;
          aborted_d   = 1'b1;
          remaining_d = '0;
        end else begin
          state_d     = st_eff;
          remaining_d = rem_eff;
          if (cnt_q == cnt_t'(1)) begin
            step_d      = 1'b1;
            position_d  = dir_q ? (position_q + pos_t'(1)) : (position_q - pos_t'(1));
            rem_dec     = rem_eff - rem_t'(1);
            remaining_d = rem_dec;
            if (rem_dec == '0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              unique case (st_eff)
                StAccel: begin
                  if (rem_dec <= span(lvl_q)) begin
                    state_d = StDecel;
                  end else if (rampcnt_q + 4'd1 == RampLast) begin
                    rampcnt_d = '0;
                    lvl_new   = lvl_q + 3'd1;
                    if (lvl_new == vmax_q) state_d = StCruise;
                  end else begin
                    rampcnt_d = rampcnt_q + 4'd1;
                  end
                end
                StCruise: begin
                  if (rem_dec <= span(lvl_q)) state_d = StDecel;
                end
                StDecel: begin
                  if ((lvl_q != 3'd0) && (rem_dec == span(lvl_q - 3'd1))) begin
                    lvl_new = lvl_q - 3'd1;
                  end
                end
                StIdle: ;
              endcase
            end
            lvl_d = lvl_new;
            cnt_d = period(lvl_new);
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      lvl_q       <= '0;
      rampcnt_q   <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      vmax_q      <= '0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      dir_q       <= 1'b1;
      position_q  <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      rampcnt_q   <= rampcnt_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      vmax_q      <= vmax_d;
      step_q      <= step_d;
      done_q      <= done_d;
      dir_q       <= dir_d;
      position_q  <= position_d;
      aborted_q   <= aborted_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy      = (state_q != StIdle);
    cmd_ready = (state_q == StIdle);
    step      = step_q;
    done      = done_q;
    dir       = dir_q;
    position  = position_q;
    aborted   = aborted_q;
  end

endmodule

// File: tb/tb_stepper_positioner.sv
// Scoreboard bench for stepper_positioner: a step-level profile model pushes
// expected step/done events; a monitor pops and compares them as they appear.
module tb_stepper_positioner;

  localparam int POS_W = 16;
  localparam int BASE  = 10;
  localparam int RAMP  = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_target = '0;
  logic [2:0]       cmd_vmax = '0;
  logic             abort = 1'b0;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             done;
  logic             aborted;

  stepper_positioner #(
    .POS_W      (POS_W),
    .BASE       (BASE),
    .RAMP_STEPS (RAMP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_vmax   (cmd_vmax),
    .abort      (abort),
    .step       (step),
    .dir        (dir),
    .position   (position),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  typedef struct {
    int          cyc;
    bit          stp;
    bit          dn;
    bit          ab;
    logic [15:0] pos;
    bit          dr;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          steps_seen = 0;
  logic [15:0] model_pos = '0;
  bit          model_dir = 1'b1;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input int c, input bit s, input bit d, input bit a,
                         input logic [15:0] p, input bit r);
    ev_t e;
    e.cyc = c; e.stp = s; e.dn = d; e.ab = a; e.pos = p; e.dr = r;
    exp_q.push_back(e);
  endtask

  // Step-level profile: walks the move one step at a time on an absolute timeline.
  // ab_after: -1 none, 0 abort right after accept, k abort right after step k.
  task automatic model_move(input int acc, input logic [15:0] from, input logic [15:0] target,
                            input int vmax, input int ab_after, output int ab_edge,
                            output int last, output logic [15:0] fin);
    int d, rem, lvl, rc, per, t, k, mode;  // mode: 0 accel, 1 cruise, 2 decel
    bit ab, dr;
    logic [15:0] p;
    d = int'($signed(target)) - int'($signed(from));
    p = from; ab_edge = -1; ab = 1'b0; t = acc; k = 0;
    if (d == 0) begin
      push_ev(acc, 1'b0, 1'b1, 1'b0, p, model_dir);
      last = acc; fin = p;
      return;
    end
    dr = (d > 0); model_dir = dr;
    rem = dr ? d : -d; lvl = 0; rc = 0; mode = (vmax == 0) ? 1 : 0; per = BASE * 8;
    if (ab_after == 0) begin
      ab_edge = acc + 1;
      push_ev(acc + 1, 1'b0, 1'b1, 1'b1, p, dr);
      last = acc + 1; fin = p;
      return;
    end
    forever begin
      t += per; k++; rem--;
      p = dr ? p + 16'd1 : p - 16'd1;
      if (rem == 0) begin
        push_ev(t, 1'b1, 1'b1, ab, p, dr);
        break;
      end
      case (mode)
        0: begin
          if (rem <= lvl * RAMP) mode = 2;
          else begin
            rc++;
            if (rc == RAMP) begin
              rc = 0; lvl++;
              if (lvl == vmax) mode = 1;
            end
          end
        end
        1: if (rem <= lvl * RAMP) mode = 2;
        default: if (lvl > 0 && rem == (lvl - 1) * RAMP) lvl--;
      endcase
      per = BASE * (8 - lvl);
      push_ev(t, 1'b1, 1'b0, ab, p, dr);
      if (ab_after == k) begin
        ab_edge = t + 1;
        if (mode != 2) begin
          if (lvl == 0) begin
            t = t + 1;
            push_ev(t, 1'b0, 1'b1, 1'b1, p, dr);
            break;
          end
          rem = (rem < lvl * RAMP) ? rem : lvl * RAMP;
          mode = 2; ab = 1'b1;
        end
      end
    end
    last = t; fin = p;
  endtask

  // Monitor: every step/done the DUT shows must match the next expected event.
  ev_t mon_e;
  initial forever begin
    @(negedge clk);
    if (rstn && (step || done)) begin
      if (step) steps_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: step=%0d done=%0d pos=%0d at cycle %0d, required none",
                 step, done, position, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", cyc, mon_e.cyc);
        chk("event_step", step, mon_e.stp);
        chk("event_done", done, mon_e.dn);
        chk("event_position", position, mon_e.pos);
        chk("event_dir", dir, mon_e.dr);
        if (mon_e.dn) chk("event_aborted", aborted, mon_e.ab);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_position", position, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    chk("rst_dir", dir, 1);
    chk("rst_aborted", aborted, 0);
  endtask

  // Asynchronous reset applied mid-cycle, outputs checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    abort = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_pos = '0; model_dir = 1'b1;
  endtask

  // Issue one command and wait for its expected events; cut > 0 abandons it early.
  task automatic run_move(input logic [15:0] target, input int vmax, input int ab_after,
                          input bit spam, input int cut);
    int acc, ab_edge, last;
    logic [15:0] fin;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !cmd_ready; n++) @(negedge clk);
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cmd_ready=0 required 1");
    end
    cmd_target = target; cmd_vmax = 3'(vmax); cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc; cmd_valid = 1'b0; steps_seen = 0;
    model_move(acc, model_pos, target, vmax, ab_after, ab_edge, last, fin);
    model_pos = fin;
    for (int n = 0; n < last - acc + 20; n++) begin
      @(negedge clk);
      if (cut > 0 && n == cut) return;
      if (ab_edge >= 0 && cyc >= ab_edge - 1) abort = 1'b1;
      if (spam) begin
        if (cyc >= acc + 100 && cyc < acc + 120) begin
          cmd_valid = 1'b1; cmd_target = 16'h1234; cmd_vmax = 3'd7;
          chk("ready_while_busy", cmd_ready, 0);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    abort = 1'b0; cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL move_timeout: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    chk("final_position", position, model_pos);
    chk("busy_after_move", busy, 0);
  endtask

  initial begin
    #12 check_reset_vals();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_no_steps", steps_seen, 0);

    // Slow move at crawl speed.
    run_move(16'd3, 0, -1, 1'b0, 0);
    chk("slow_steps", steps_seen, 3);
    chk("slow_pos", position, 3);

    // Reset in the middle of a move.
    run_move(16'd40, 3, -1, 1'b0, 150);
    do_reset();

    // Full trapezoid 0 -> 100.
    run_move(16'd100, 7, -1, 1'b0, 0);
    chk("trap_steps", steps_seen, 100);
    chk("trap_pos", position, 100);

    // Short move that never reaches higher levels.
    run_move(16'd110, 7, -1, 1'b0, 0);
    chk("tri_steps", steps_seen, 10);

    // Negative move wrapping through zero, with an ignored command mid-move.
    do_reset();
    run_move(16'd5, 2, -1, 1'b0, 0);
    run_move(16'hFFFE, 7, -1, 1'b1, 0);
    chk("wrap_steps", steps_seen, 7);
    chk("wrap_pos", position, 16'hFFFE);
    chk("wrap_dir", dir, 0);

    // Target equal to position: done only.
    run_move(16'hFFFE, 4, -1, 1'b0, 0);
    chk("zero_move_steps", steps_seen, 0);

    // Abort during cruise at level 7 with 50 steps left.
    do_reset();
    run_move(16'd100, 7, 50, 1'b0, 0);
    chk("abort_cruise_steps", steps_seen, 78);
    chk("abort_cruise_flag", aborted, 1);

    // Abort at level 0: stop with no further step.
    run_move(16'd98, 5, 2, 1'b0, 0);
    chk("abort_crawl_steps", steps_seen, 2);
    chk("abort_crawl_pos", position, 80);
    chk("abort_crawl_flag", aborted, 1);

    // Randomized moves, some aborted.
    for (int r = 0; r < 6; r++) begin
      int d, v, ab;
      d = int'($urandom_range(0, 80)) - 40;
      v = int'($urandom_range(0, 7));
      ab = -1;
      if (d != 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(0, (d < 0 ? -d : d) - 1));
      run_move(model_pos + 16'(d), v, ab, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
